// File: rtl/softmax_pkg.sv
// Shared constants, state encoding and group-length helper for the softmax
// max-stage issue scheduler.
package softmax_pkg;

    localparam int unsigned LAT       = 12;
    localparam logic [3:0]  GROUP_MIN = 4'd3;
    localparam logic [3:0]  GROUP_MAX = 4'd13;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BUBBLE,
        ST_DRAIN
    } state_e;

    function automatic logic is_group(input logic [3:0] mode);
        return (mode >= GROUP_MIN) && (mode <= GROUP_MAX);
    endfunction

    // Beats per group: lm-1 for group modes, 1 for single-beat modes.
    function automatic logic [3:0] grp_len(input logic [3:0] mode);
        return is_group(mode) ? (mode - 4'd1) : 4'd1;
    endfunction

endpackage

// File: rtl/softmax_max_sched_issue_window.sv
// Enable-gated shadow of the valids in flight through max_forwarding.
module issue_window #(
    parameter int unsigned LAT = 12
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_valid,
    output logic o_empty
);

    logic [LAT-1:0] win_q;
    logic [LAT-1:0] win_d;

    always_comb begin
        win_d = win_q;
        if (i_en) begin
            win_d = {win_q[LAT-2:0], i_valid};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign o_empty = (win_q == '0);

endmodule

// File: rtl/softmax_max_sched.sv
// Issue scheduler in front of max_forwarding: enforces group framing, inserts
// bubbles at group ends and class changes, and drains the pipeline on request.
module softmax_max_sched #(
    parameter int unsigned DATA_W = 1024,
    parameter int unsigned LAT    = softmax_pkg::LAT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [3:0]          i_length_mode,
    input  logic signed [15:0]  i_loc_max,
    input  logic [DATA_W-1:0]   i_in_flat,
    input  logic                i_stall,
    input  logic                i_flush,
    output logic                o_en,
    output logic                o_valid_max,
    output logic [3:0]          o_length_mode,
    output logic signed [15:0]  o_loc_max,
    output logic [DATA_W-1:0]   o_in_flat,
    output logic                o_flush_done,
    output logic                o_idle,
    output logic                o_err_mode
);
    import softmax_pkg::*;

    state_e              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [3:0]          cur_mode_q, cur_mode_d;
    logic                prev_grp_q, prev_grp_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    logic [3:0]          mode_q, mode_d;
    logic signed [15:0]  loc_q, loc_d;
    logic [DATA_W-1:0]   flat_q, flat_d;

    logic       en, is_first, in_grp, class_chg, bubble_pending, accept;
    logic       beat_grp, last_beat, win_empty, flush_done;
    logic [3:0] issue_mode;

    assign en             = ~i_stall;
    assign is_first       = (idx_q == 4'd0);
    assign in_grp         = is_group(i_length_mode);
    // A first beat of the other class is held back one cycle; that cycle is the bubble.
    assign class_chg      = (state_q == ST_RUN) & is_first & i_valid & (in_grp != prev_grp_q);
    assign bubble_pending = (state_q == ST_BUBBLE) | class_chg;
    assign o_ready        = i_rst_n & (state_q == ST_RUN) & en & ~bubble_pending;
    assign accept         = i_valid & o_ready;
    assign issue_mode     = is_first ? i_length_mode : cur_mode_q;
    assign beat_grp       = is_first ? in_grp : 1'b1;
    assign last_beat      = (idx_q == (grp_len(issue_mode) - 4'd1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_mode_d = cur_mode_q;
        prev_grp_d = prev_grp_q;
        err_d      = err_q;
        valid_d    = valid_q;
        mode_d     = mode_q;
        loc_d      = loc_q;
        flat_d     = flat_q;
        flush_done = 1'b0;
        if (en) begin
            valid_d = 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        valid_d    = 1'b1;
                        mode_d     = issue_mode;
                        loc_d      = i_loc_max;
                        flat_d     = i_in_flat;
                        cur_mode_d = issue_mode;
                        prev_grp_d = beat_grp;
                        if (!is_first && (i_length_mode != cur_mode_q)) begin
                            err_d = 1'b1;
                        end
                        if (beat_grp) begin
                            if (last_beat) begin
                                idx_d   = 4'd0;
                                state_d = ST_BUBBLE;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                    end else if (class_chg) begin
                        prev_grp_d = in_grp;
                    end
                    if (i_flush && is_first && !bubble_pending && !(accept && beat_grp)) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_BUBBLE: state_d = i_flush ? ST_DRAIN : ST_RUN;
                ST_DRAIN: begin
                    if (win_empty) begin
                        flush_done = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_RUN;
            idx_q      <= '0;
            cur_mode_q <= '0;
            prev_grp_q <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            mode_q     <= '0;
            loc_q      <= '0;
            flat_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_mode_q <= cur_mode_d;
            prev_grp_q <= prev_grp_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            mode_q     <= mode_d;
            loc_q      <= loc_d;
            flat_q     <= flat_d;
        end
    end

    issue_window #(.LAT(LAT)) u_window (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (en),
        .i_valid (valid_q),
        .o_empty (win_empty)
    );

    assign o_en          = en;
    assign o_valid_max   = valid_q;
    assign o_length_mode = mode_q;
    assign o_loc_max     = loc_q;
    assign o_in_flat     = flat_q;
    assign o_err_mode    = err_q;
    assign o_flush_done  = flush_done & i_rst_n;
    assign o_idle        = (state_q == ST_RUN) & is_first & win_empty;

endmodule

// File: tb/tb_softmax_max_sched.sv
// Directed bench for softmax_max_sched: group framing, bubbles, stall, flush, reset.
module tb_softmax_max_sched;

    localparam int unsigned DATA_W = 1024;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid;
    logic               ready;
    logic [3:0]         lmode;
    logic signed [15:0] loc;
    logic [DATA_W-1:0]  flat;
    logic               stall;
    logic               flush;
    logic               en;
    logic               vmax;
    logic [3:0]         omode;
    logic signed [15:0] oloc;
    logic [DATA_W-1:0]  oflat;
    logic               fdone;
    logic               idle;
    logic               err;

    int checks = 0;
    int errors = 0;

    softmax_max_sched #(.DATA_W(DATA_W), .LAT(12)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_length_mode (lmode),
        .i_loc_max     (loc),
        .i_in_flat     (flat),
        .i_stall       (stall),
        .i_flush       (flush),
        .o_en          (en),
        .o_valid_max   (vmax),
        .o_length_mode (omode),
        .o_loc_max     (oloc),
        .o_in_flat     (oflat),
        .o_flush_done  (fdone),
        .o_idle        (idle),
        .o_err_mode    (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_loc(input logic [15:0] v);
        loc  = v;
        flat = {64{v}};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1; lmode = 4'd5; set_loc(16'h1234);
        stall = 1'b0; flush = 1'b0;
        tick(); tick();
        checks++; if (vmax !== 1'b0) begin errors++; $display("FAIL rst_vmax got %b want 0", vmax); end
        checks++; if (omode !== 4'd0) begin errors++; $display("FAIL rst_mode got %0d want 0", omode); end
        checks++; if (oloc !== 16'sd0) begin errors++; $display("FAIL rst_loc got %h want 0000", oloc); end
        checks++; if (oflat !== '0) begin errors++; $display("FAIL rst_flat nonzero"); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        checks++; if (fdone !== 1'b0) begin errors++; $display("FAIL rst_fdone got %b want 0", fdone); end
        rst_n = 1'b1; valid = 1'b0;
        tick();
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b want 1", idle); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready_run got %b want 1", ready); end
    endtask

    // First group after reset follows a single-class history, so a class bubble leads.
    task automatic test_group5();
        logic [0:10] exp_acc = 11'b01111011110;
        logic [15:0] locs [9] = '{16'd100, 16'd101, 16'd102, 16'd1099,
                                  16'd200, 16'd201, 16'd202, 16'd203, 16'd0};
        int k = 0;
        valid = 1'b1; lmode = 4'd5;
        for (int c = 0; c < 11; c++) begin
            set_loc(locs[k]);
            #1;
            checks++; if (ready !== exp_acc[c]) begin errors++; $display("FAIL g5_ready c%0d got %b want %b", c, ready, exp_acc[c]); end
            checks++; if (en !== 1'b1) begin errors++; $display("FAIL g5_en c%0d got %b want 1", c, en); end
            tick();
            checks++; if (vmax !== exp_acc[c]) begin errors++; $display("FAIL g5_vmax c%0d got %b want %b", c, vmax, exp_acc[c]); end
            if (exp_acc[c]) begin
                checks++; if (oloc !== locs[k]) begin errors++; $display("FAIL g5_loc c%0d got %0d want %0d", c, oloc, locs[k]); end
                checks++; if (omode !== 4'd5) begin errors++; $display("FAIL g5_mode c%0d got %0d want 5", c, omode); end
                checks++; if (oflat !== {64{locs[k]}}) begin errors++; $display("FAIL g5_flat c%0d", c); end
                k++;
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_group13_3();
        logic [0:15] exp_acc = 16'b1111111111110110;
        logic [3:0]  want_mode;
        valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            lmode = (c < 12) ? 4'd13 : 4'd3;
            want_mode = lmode;
            set_loc(16'h0300 + 16'(c));
            #1;
            checks++; if (ready !== exp_acc[c]) begin errors++; $display("FAIL g13_ready c%0d got %b want %b", c, ready, exp_acc[c]); end
            tick();
            checks++; if (vmax !== exp_acc[c]) begin errors++; $display("FAIL g13_vmax c%0d got %b want %b", c, vmax, exp_acc[c]); end
            if (exp_acc[c]) begin
                checks++; if (omode !== want_mode) begin errors++; $display("FAIL g13_mode c%0d got %0d want %0d", c, omode, want_mode); end
                checks++; if (oloc !== (16'h0300 + 16'(c))) begin errors++; $display("FAIL g13_loc c%0d got %h", c, oloc); end
            end
        end
        valid = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL g13_err got %b want 0", err); end
    endtask

    task automatic test_singles();
        logic [0:8] exp_acc = 9'b011101110;
        logic [3:0] want_mode;
        valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            lmode = (c < 4) ? 4'd1 : 4'd4;
            want_mode = lmode;
            set_loc(16'h0500 + 16'(c));
            #1;
            checks++; if (ready !== exp_acc[c]) begin errors++; $display("FAIL sgl_ready c%0d got %b want %b", c, ready, exp_acc[c]); end
            tick();
            checks++; if (vmax !== exp_acc[c]) begin errors++; $display("FAIL sgl_vmax c%0d got %b want %b", c, vmax, exp_acc[c]); end
            if (exp_acc[c]) begin
                checks++; if (omode !== want_mode) begin errors++; $display("FAIL sgl_mode c%0d got %0d want %0d", c, omode, want_mode); end
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_err_mode();
        logic [0:5] exp_acc = 6'b111110;
        valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            lmode = (c == 2) ? 4'd7 : 4'd6;
            set_loc(16'h0600 + 16'(c));
            #1;
            checks++; if (ready !== exp_acc[c]) begin errors++; $display("FAIL err_ready c%0d got %b want %b", c, ready, exp_acc[c]); end
            tick();
            checks++; if (vmax !== exp_acc[c]) begin errors++; $display("FAIL err_vmax c%0d got %b want %b", c, vmax, exp_acc[c]); end
            checks++; if (err !== (c >= 2)) begin errors++; $display("FAIL err_flag c%0d got %b want %b", c, err, (c >= 2)); end
            if (exp_acc[c]) begin
                checks++; if (omode !== 4'd6) begin errors++; $display("FAIL err_mode c%0d got %0d want 6", c, omode); end
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [0:2] exp_acc = 3'b110;
        valid = 1'b1; lmode = 4'd4; set_loc(16'h0400);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL stl_ready0 got %b want 1", ready); end
        tick();
        checks++; if (vmax !== 1'b1) begin errors++; $display("FAIL stl_vmax0 got %b want 1", vmax); end
        stall = 1'b1; set_loc(16'h0401);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (en !== 1'b0) begin errors++; $display("FAIL stl_en c%0d got %b want 0", c, en); end
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL stl_ready c%0d got %b want 0", c, ready); end
            tick();
            checks++; if (vmax !== 1'b1 || oloc !== 16'sh0400 || omode !== 4'd4) begin
                errors++; $display("FAIL stl_hold c%0d got v=%b loc=%h mode=%0d want v=1 loc=0400 mode=4", c, vmax, oloc, omode);
            end
        end
        stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_loc(16'h0401 + 16'(c));
            #1;
            checks++; if (ready !== exp_acc[c]) begin errors++; $display("FAIL stl_post_ready c%0d got %b want %b", c, ready, exp_acc[c]); end
            tick();
            checks++; if (vmax !== exp_acc[c]) begin errors++; $display("FAIL stl_post_vmax c%0d got %b want %b", c, vmax, exp_acc[c]); end
            if (exp_acc[c]) begin
                checks++; if (oloc !== (16'h0401 + 16'(c))) begin errors++; $display("FAIL stl_post_loc c%0d got %h", c, oloc); end
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_flush();
        logic [0:7] exp_acc = 8'b11111110;
        int pulses = 0;
        valid = 1'b1; lmode = 4'd8;
        for (int c = 0; c < 8; c++) begin
            flush = (c >= 1);
            set_loc(16'h0800 + 16'(c));
            #1;
            checks++; if (ready !== exp_acc[c]) begin errors++; $display("FAIL fl_ready c%0d got %b want %b", c, ready, exp_acc[c]); end
            tick();
            checks++; if (vmax !== exp_acc[c]) begin errors++; $display("FAIL fl_vmax c%0d got %b want %b", c, vmax, exp_acc[c]); end
        end
        flush = 1'b0; valid = 1'b0;
        for (int d = 0; d < 13; d++) begin
            #1;
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fl_drain_ready d%0d got %b want 0", d, ready); end
            checks++; if (fdone !== (d == 12)) begin errors++; $display("FAIL fl_done d%0d got %b want %b", d, fdone, (d == 12)); end
            if (fdone === 1'b1) pulses++;
            tick();
        end
        #1;
        checks++; if (pulses != 1) begin errors++; $display("FAIL fl_pulses got %0d want 1", pulses); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL fl_idle got %b want 1", idle); end
        checks++; if (fdone !== 1'b0) begin errors++; $display("FAIL fl_done_after got %b want 0", fdone); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fl_ready_after got %b want 1", ready); end
    endtask

    task automatic test_reset_mid_group();
        valid = 1'b1; lmode = 4'd8;
        for (int c = 0; c < 2; c++) begin
            set_loc(16'h0900 + 16'(c));
            #1;
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_ready c%0d got %b want 1", c, ready); end
            tick();
        end
        rst_n = 1'b0;
        tick();
        checks++; if (vmax !== 1'b0 || omode !== 4'd0 || oloc !== 16'sd0 || oflat !== '0) begin
            errors++; $display("FAIL rm_outputs got v=%b mode=%0d loc=%h want 0/0/0000", vmax, omode, oloc);
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rm_err got %b want 0", err); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rm_ready_rst got %b want 0", ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rm_idle got %b want 1", idle); end
        rst_n = 1'b1; lmode = 4'd1; set_loc(16'h0101);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_ready_single got %b want 1", ready); end
        tick();
        checks++; if (vmax !== 1'b1 || omode !== 4'd1 || oloc !== 16'sh0101) begin
            errors++; $display("FAIL rm_single got v=%b mode=%0d loc=%h want 1/1/0101", vmax, omode, oloc);
        end
        valid = 1'b0;
        tick();
        checks++; if (vmax !== 1'b0) begin errors++; $display("FAIL rm_vmax_end got %b want 0", vmax); end
    endtask

    initial begin
        test_reset();
        test_group5();
        test_group13_3();
        test_singles();
        test_err_mode();
        test_stall();
        test_flush();
        test_reset_mid_group();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
